// File: rtl/triplet_loader_pkg.sv
// Shared definitions for the triplet loader and the comparator it feeds:
// FSM state encoding and the default operand width.
package triplet_loader_pkg;

    localparam int N_DEF     = 5;
    localparam int CNT_W_DEF = 8;

    typedef enum logic [1:0] {
        LOAD_A = 2'd0,
        LOAD_B = 2'd1,
        LOAD_C = 2'd2,
        HOLD   = 2'd3
    } state_t;

endpackage

// File: rtl/triplet_loader_if.sv
// Word stream in, operand triplet out, each with its own valid/ready pair.
// A transfer happens on a rising edge where valid && ready; valid never waits on ready.
interface triplet_loader_if #(
    parameter int N = triplet_loader_pkg::N_DEF
);
    logic [N-1:0] in_data;
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] a_out;
    logic [N-1:0] b_out;
    logic [N-1:0] c_out;
    logic         trip_valid;
    logic         trip_ready;

    // master: the loader, which sinks the word stream and sources the triplet
    modport master (
        input  in_data, in_valid, trip_ready,
        output in_ready, a_out, b_out, c_out, trip_valid
    );

    // slave: the producer/consumer environment around the loader
    modport slave (
        output in_data, in_valid, trip_ready,
        input  in_ready, a_out, b_out, c_out, trip_valid
    );

endinterface

// File: rtl/triplet_loader.sv
// Groups a serial word stream into A/B/C triplets and holds each one stable on
// registered buses until the comparator side accepts it.
module triplet_loader
    import triplet_loader_pkg::*;
#(
    parameter int N     = N_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    triplet_loader_if.master  bus,
    output logic [CNT_W-1:0]  trip_count,
    output logic              busy,
    output state_t            dbg_state
);

    state_t           state;
    state_t           state_nxt;
    logic [N-1:0]     a_q;
    logic [N-1:0]     b_q;
    logic [N-1:0]     c_q;
    logic             trip_valid_q;
    logic [CNT_W-1:0] count_q;
    logic             in_ready_c;
    logic             accept;
    logic             deliver;

    assign accept  = bus.in_valid && in_ready_c;
    assign deliver = trip_valid_q && bus.trip_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= LOAD_A;
        end else begin
            state <= state_nxt;
        end
    end

    // Flush wins over every transition, including a HOLD that is also delivering.
    always_comb begin
        state_nxt = state;
        if (flush) begin
            state_nxt = LOAD_A;
        end else begin
            case (state)
                LOAD_A: if (accept) state_nxt = LOAD_B;
                LOAD_B: if (accept) state_nxt = LOAD_C;
                LOAD_C: if (accept) state_nxt = HOLD;
                HOLD:   if (deliver) state_nxt = accept ? LOAD_B : LOAD_A;
                default: state_nxt = LOAD_A;
            endcase
        end
    end

    // In HOLD the loader can only take a word when the held triplet leaves this cycle.
    always_comb begin
        in_ready_c = !flush && ((state != HOLD) || bus.trip_ready);
        busy       = (state != LOAD_A);
        dbg_state  = state;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            trip_valid_q <= 1'b0;
        end else begin
            trip_valid_q <= (state_nxt == HOLD);
        end
    end

    // A word accepted while leaving HOLD is the next triplet's A operand.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q <= '0;
            b_q <= '0;
            c_q <= '0;
        end else if (accept) begin
            case (state)
                LOAD_B:  b_q <= bus.in_data;
                LOAD_C:  c_q <= bus.in_data;
                default: a_q <= bus.in_data;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else if (deliver) begin
            count_q <= count_q + CNT_W'(1);
        end
    end

    assign bus.in_ready   = in_ready_c;
    assign bus.a_out      = a_q;
    assign bus.b_out      = b_q;
    assign bus.c_out      = c_q;
    assign bus.trip_valid = trip_valid_q;
    assign trip_count     = count_q;

endmodule

// File: tb/tb_triplet_loader.sv
// Bench for triplet_loader: a default-width-counter instance and a 2-bit-counter
// instance see identical stimulus and are checked against a queue-based model.
module tb_triplet_loader;
    import triplet_loader_pkg::*;

    localparam int N = 5;

    logic clk = 1'b0;
    logic rst_n;
    logic flush;

    triplet_loader_if #(.N(N)) mif ();
    triplet_loader_if #(.N(N)) wif ();

    logic [7:0] cnt8;
    logic [1:0] cnt2;
    logic       busy8;
    logic       busy2;
    state_t     st8;
    state_t     st2;

    assign wif.in_data    = mif.in_data;
    assign wif.in_valid   = mif.in_valid;
    assign wif.trip_ready = mif.trip_ready;

    triplet_loader #(.N(N), .CNT_W(8)) u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (flush),
        .bus        (mif),
        .trip_count (cnt8),
        .busy       (busy8),
        .dbg_state  (st8)
    );

    triplet_loader #(.N(N), .CNT_W(2)) u_wrap (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (flush),
        .bus        (wif),
        .trip_count (cnt2),
        .busy       (busy2),
        .dbg_state  (st2)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference model: accepted-but-undelivered words in order, fill level of the
    // triplet being built, whether a complete triplet is held, and last operands.
    logic [N-1:0] exp_q[$];
    int           m_fill;
    bit           m_held;
    logic [N-1:0] m_a, m_b, m_c;
    int           m_cnt;

    task automatic model_reset();
        exp_q.delete();
        m_fill = 0;
        m_held = 1'b0;
        m_a    = '0;
        m_b    = '0;
        m_c    = '0;
        m_cnt  = 0;
    endtask

    function automatic bit model_ready();
        return !flush && (!m_held || mif.trip_ready);
    endfunction

    function automatic logic [1:0] model_state();
        return m_held ? 2'd3 : 2'(m_fill);
    endfunction

    function automatic logic [3*N+3:0] exp_vec();
        return {m_a, m_b, m_c, m_held, (m_held || m_fill != 0), model_state()};
    endfunction

    task automatic drive(input bit v, input logic [N-1:0] d, input bit tr, input bit fl);
        mif.in_valid   = v;
        mif.in_data    = d;
        mif.trip_ready = tr;
        flush          = fl;
    endtask

    // Advance one clock and apply the same edge to the model.
    task automatic step();
        bit           acc;
        bit           dlv;
        logic [N-1:0] d;
        acc = mif.in_valid && model_ready();
        dlv = m_held && mif.trip_ready;
        d   = mif.in_data;
        @(posedge clk);
        if (dlv) begin
            m_cnt++;
            repeat (3) void'(exp_q.pop_front());
            m_held = 1'b0;
        end
        if (flush) begin
            exp_q.delete();
            m_fill = 0;
            m_held = 1'b0;
        end else if (acc) begin
            exp_q.push_back(d);
            case (m_fill)
                0:       m_a = d;
                1:       m_b = d;
                default: m_c = d;
            endcase
            if (m_fill == 2) begin
                m_fill = 0;
                m_held = 1'b1;
            end else begin
                m_fill++;
            end
        end
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drive(1'b0, '0, 1'b0, 1'b0);
        model_reset();
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        #1;
        checks++;
        if ({mif.a_out, mif.b_out, mif.c_out, mif.trip_valid, busy8, st8} !== '0) begin
            failures++;
            $display("FAIL reset_outputs got a=%0h b=%0h c=%0h tv=%0b busy=%0b st=%0d exp all zero",
                     mif.a_out, mif.b_out, mif.c_out, mif.trip_valid, busy8, st8);
        end
        checks++;
        if (cnt8 !== 8'd0 || cnt2 !== 2'd0) begin
            failures++;
            $display("FAIL reset_count got %0d/%0d exp 0/0", cnt8, cnt2);
        end
        checks++;
        if (mif.in_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_in_ready got %0b exp 1", mif.in_ready);
        end
    endtask

    task automatic test_hold_stable();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 5'h03, 1'b0, 1'b0);
            step();
        end
        checks++;
        if ({mif.a_out, mif.b_out, mif.c_out, mif.trip_valid, mif.in_ready} !== {5'd3, 5'd3, 5'd3, 1'b1, 1'b0}) begin
            failures++;
            $display("FAIL hold_first got a=%0h b=%0h c=%0h tv=%0b rdy=%0b exp 3/3/3 tv=1 rdy=0",
                     mif.a_out, mif.b_out, mif.c_out, mif.trip_valid, mif.in_ready);
        end
        for (int i = 0; i < 10; i++) begin
            step();
            checks++;
            if ({mif.a_out, mif.b_out, mif.c_out, mif.trip_valid, mif.in_ready, st8} !==
                {5'd3, 5'd3, 5'd3, 1'b1, 1'b0, HOLD}) begin
                failures++;
                $display("FAIL hold_stable cycle %0d got a=%0h b=%0h c=%0h tv=%0b rdy=%0b st=%0d",
                         i, mif.a_out, mif.b_out, mif.c_out, mif.trip_valid, mif.in_ready, st8);
            end
        end
        drive(1'b0, '0, 1'b1, 1'b0);
        step();
        checks++;
        if (mif.trip_valid !== 1'b0 || cnt8 !== 8'd1 || st8 !== LOAD_A) begin
            failures++;
            $display("FAIL hold_release got tv=%0b cnt=%0d st=%0d exp tv=0 cnt=1 st=0",
                     mif.trip_valid, cnt8, st8);
        end
    endtask

    task automatic test_back_to_back();
        int start;
        start = m_cnt;
        for (int i = 0; i < 9; i++) begin
            drive(1'b1, 5'(i + 1), 1'b1, 1'b0);
            #1;
            checks++;
            if (mif.in_ready !== 1'b1) begin
                failures++;
                $display("FAIL b2b_in_ready word %0d got %0b exp 1", i + 1, mif.in_ready);
            end
            step();
            checks++;
            if (mif.trip_valid !== (i % 3 == 2)) begin
                failures++;
                $display("FAIL b2b_trip_valid after word %0d got %0b exp %0b", i + 1, mif.trip_valid, (i % 3 == 2));
            end
            if (i % 3 == 2) begin
                checks++;
                if ({mif.a_out, mif.b_out, mif.c_out} !== {5'(i - 1), 5'(i), 5'(i + 1)}) begin
                    failures++;
                    $display("FAIL b2b_triplet got %0d/%0d/%0d exp %0d/%0d/%0d",
                             mif.a_out, mif.b_out, mif.c_out, i - 1, i, i + 1);
                end
            end
        end
        drive(1'b0, '0, 1'b1, 1'b0);
        step();
        checks++;
        if (cnt8 !== 8'(start + 3) || mif.trip_valid !== 1'b0) begin
            failures++;
            $display("FAIL b2b_count got cnt=%0d tv=%0b exp cnt=%0d tv=0", cnt8, mif.trip_valid, start + 3);
        end
    endtask

    task automatic test_backpressure();
        drive(1'b1, 5'h1F, 1'b0, 1'b0); step();
        drive(1'b1, 5'h10, 1'b0, 1'b0); step();
        drive(1'b1, 5'h01, 1'b0, 1'b0); step();
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 5'h0A, 1'b0, 1'b0);
            #1;
            checks++;
            if (mif.in_ready !== 1'b0) begin
                failures++;
                $display("FAIL bp_in_ready cycle %0d got %0b exp 0", i, mif.in_ready);
            end
            step();
            checks++;
            if ({mif.a_out, mif.b_out, mif.c_out, mif.trip_valid} !== {5'h1F, 5'h10, 5'h01, 1'b1}) begin
                failures++;
                $display("FAIL bp_hold got %0h/%0h/%0h tv=%0b exp 1f/10/01 tv=1",
                         mif.a_out, mif.b_out, mif.c_out, mif.trip_valid);
            end
        end
        drive(1'b1, 5'h0A, 1'b1, 1'b0);
        #1;
        checks++;
        if (mif.in_ready !== 1'b1) begin
            failures++;
            $display("FAIL bp_release_ready got %0b exp 1", mif.in_ready);
        end
        step();
        checks++;
        if (mif.a_out !== 5'h0A || st8 !== LOAD_B || mif.trip_valid !== 1'b0) begin
            failures++;
            $display("FAIL bp_capture got a=%0h st=%0d tv=%0b exp a=0a st=1 tv=0", mif.a_out, st8, mif.trip_valid);
        end
        drive(1'b0, '0, 1'b0, 1'b0);
    endtask

    task automatic test_flush_partial();
        int start;
        drive(1'b0, '0, 1'b0, 1'b1);
        step();
        start = m_cnt;
        drive(1'b1, 5'd7, 1'b0, 1'b0); step();
        drive(1'b1, 5'd8, 1'b0, 1'b0); step();
        checks++;
        if (st8 !== LOAD_C) begin
            failures++;
            $display("FAIL flush_pre_state got %0d exp 2", st8);
        end
        drive(1'b1, 5'd9, 1'b0, 1'b1);
        #1;
        checks++;
        if (mif.in_ready !== 1'b0) begin
            failures++;
            $display("FAIL flush_in_ready got %0b exp 0", mif.in_ready);
        end
        step();
        checks++;
        if (st8 !== LOAD_A || busy8 !== 1'b0 || cnt8 !== 8'(start)) begin
            failures++;
            $display("FAIL flush_partial got st=%0d busy=%0b cnt=%0d exp st=0 busy=0 cnt=%0d", st8, busy8, cnt8, start);
        end
        for (int i = 1; i <= 3; i++) begin
            drive(1'b1, 5'(i), 1'b0, 1'b0);
            step();
        end
        checks++;
        if ({mif.a_out, mif.b_out, mif.c_out, mif.trip_valid} !== {5'd1, 5'd2, 5'd3, 1'b1}) begin
            failures++;
            $display("FAIL flush_reload got %0d/%0d/%0d tv=%0b exp 1/2/3 tv=1",
                     mif.a_out, mif.b_out, mif.c_out, mif.trip_valid);
        end
        drive(1'b0, '0, 1'b1, 1'b0);
        step();
        checks++;
        if (cnt8 !== 8'(start + 1)) begin
            failures++;
            $display("FAIL flush_count got %0d exp %0d", cnt8, start + 1);
        end
    endtask

    task automatic test_flush_deliver();
        int start;
        for (int i = 4; i <= 6; i++) begin
            drive(1'b1, 5'(i), 1'b0, 1'b0);
            step();
        end
        start = m_cnt;
        drive(1'b1, 5'd9, 1'b1, 1'b1);
        #1;
        checks++;
        if (mif.in_ready !== 1'b0) begin
            failures++;
            $display("FAIL flushdlv_in_ready got %0b exp 0", mif.in_ready);
        end
        step();
        checks++;
        if (cnt8 !== 8'(start + 1) || cnt2 !== 2'(start + 1)) begin
            failures++;
            $display("FAIL flushdlv_count got %0d/%0d exp %0d", cnt8, cnt2, start + 1);
        end
        checks++;
        if (mif.trip_valid !== 1'b0 || st8 !== LOAD_A || mif.a_out !== 5'd4) begin
            failures++;
            $display("FAIL flushdlv_state got tv=%0b st=%0d a=%0d exp tv=0 st=0 a=4", mif.trip_valid, st8, mif.a_out);
        end
        drive(1'b0, '0, 1'b0, 1'b0);
    endtask

    task automatic test_wrap_and_async_reset();
        int seq [5] = '{1, 2, 3, 0, 1};
        rst_n = 1'b0;
        model_reset();
        @(posedge clk);
        #3 rst_n = 1'b1;
        #1;
        for (int k = 0; k < 5; k++) begin
            for (int j = 0; j < 3; j++) begin
                drive(1'b1, 5'($urandom_range(0, 31)), 1'b0, 1'b0);
                step();
            end
            drive(1'b0, '0, 1'b1, 1'b0);
            step();
            checks++;
            if (cnt2 !== 2'(seq[k]) || cnt8 !== 8'(k + 1)) begin
                failures++;
                $display("FAIL wrap_count triplet %0d got %0d/%0d exp %0d/%0d", k, cnt2, cnt8, seq[k], k + 1);
            end
        end
        drive(1'b1, 5'h15, 1'b0, 1'b0);
        step();
        drive(1'b0, '0, 1'b0, 1'b0);
        checks++;
        if (st8 !== LOAD_B || mif.a_out !== 5'h15) begin
            failures++;
            $display("FAIL areset_pre got st=%0d a=%0h exp st=1 a=15", st8, mif.a_out);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({mif.a_out, mif.b_out, mif.c_out, mif.trip_valid, cnt8, busy8, st8} !== '0 ||
            {wif.a_out, wif.b_out, wif.c_out, wif.trip_valid, cnt2, busy2, st2} !== '0) begin
            failures++;
            $display("FAIL areset_clear got a=%0h b=%0h c=%0h tv=%0b cnt=%0d busy=%0b st=%0d wcnt=%0d exp all zero",
                     mif.a_out, mif.b_out, mif.c_out, mif.trip_valid, cnt8, busy8, st8, cnt2);
        end
        model_reset();
        @(posedge clk);
        #3 rst_n = 1'b1;
        #1;
    endtask

    task automatic test_random();
        bit           v;
        bit           tr;
        bit           fl;
        logic [N-1:0] d;
        for (int c = 0; c < 400; c++) begin
            v  = ($urandom_range(0, 9) < 7);
            tr = $urandom_range(0, 1) == 1;
            fl = ($urandom_range(0, 19) == 0);
            d  = 5'($urandom_range(0, 31));
            drive(v, d, tr, fl);
            #1;
            checks++;
            if (mif.in_ready !== model_ready()) begin
                failures++;
                $display("FAIL rand_in_ready cycle %0d got %0b exp %0b", c, mif.in_ready, model_ready());
            end
            if (m_held && tr) begin
                checks++;
                if ({mif.a_out, mif.b_out, mif.c_out} !== {exp_q[0], exp_q[1], exp_q[2]}) begin
                    failures++;
                    $display("FAIL rand_delivery cycle %0d got %0h/%0h/%0h exp %0h/%0h/%0h",
                             c, mif.a_out, mif.b_out, mif.c_out, exp_q[0], exp_q[1], exp_q[2]);
                end
            end
            step();
            checks++;
            if ({mif.a_out, mif.b_out, mif.c_out, mif.trip_valid, busy8, st8} !== exp_vec() ||
                {wif.a_out, wif.b_out, wif.c_out, wif.trip_valid, busy2, st2} !== exp_vec()) begin
                failures++;
                $display("FAIL rand_outputs cycle %0d got %0h wrap %0h exp %0h", c,
                         {mif.a_out, mif.b_out, mif.c_out, mif.trip_valid, busy8, st8},
                         {wif.a_out, wif.b_out, wif.c_out, wif.trip_valid, busy2, st2}, exp_vec());
            end
            checks++;
            if ({cnt8, cnt2} !== {8'(m_cnt), 2'(m_cnt)}) begin
                failures++;
                $display("FAIL rand_count cycle %0d got %0d/%0d exp %0d/%0d", c, cnt8, cnt2, 8'(m_cnt), 2'(m_cnt));
            end
        end
        drive(1'b0, '0, 1'b0, 1'b0);
    endtask

    initial begin
        test_reset();
        test_hold_stable();
        test_back_to_back();
        test_backpressure();
        test_flush_partial();
        test_flush_deliver();
        test_wrap_and_async_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
